risc_mgmt_mem_arbiter: RTL



---
 rtl/risc_mgmt_arb_pkg.sv | 16 +
 rtl/risc_mgmt_mem_arbiter_rr_picker.sv | 36 +++
 rtl/risc_mgmt_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/risc_mgmt_arb_pkg.sv
// Shared types for the RISC-MGMT memory-port arbiter.
// Pure declarations: no logic, no latency, no flow control.
package risc_mgmt_arb_pkg;

    localparam int WORD_W         = 32;
    localparam int NUM_EXTENSIONS = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ABORT
    } arb_state_t;

endpackage

// File: rtl/risc_mgmt_mem_arbiter_rr_picker.sv
// Round-robin pick of the first valid requester after last.
// Combinational, zero latency; no backpressure of its own.
module rr_picker
    import risc_mgmt_arb_pkg::*;
#(
    parameter int NUM_EXT = NUM_EXTENSIONS,
    parameter int IDX_W   = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
    input  logic [NUM_EXT-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_EXT-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int               c;
        logic [IDX_W-1:0] ci;
        c   = 0;
        ci  = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Search starts one past the previous owner so it gets lowest priority.
        for (int k = 1; k <= NUM_EXT; k++) begin
            c  = (int'(last) + k) % NUM_EXT;
            ci = IDX_W'(c);
            if (!any && valid[ci]) begin
                any     = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/risc_mgmt_mem_arbiter.sv
// Shares the RISC-MGMT memory port among extensions, one access at a time.
// Min latency 2 cycles (grant+strobe, then done); mem_busy stretches the access, stall held meanwhile.
module risc_mgmt_mem_arbiter
    import risc_mgmt_arb_pkg::*;
#(
    parameter int NUM_EXT = NUM_EXTENSIONS,
    parameter int TIMEOUT = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_EXT-1:0]        ext_req,
    input  logic [NUM_EXT-1:0]        ext_ren,
    input  logic [NUM_EXT-1:0]        ext_wen,
    input  logic [NUM_EXT*WORD_W-1:0] ext_addr,
    input  logic [NUM_EXT*WORD_W-1:0] ext_wdata,
    output logic [NUM_EXT-1:0]        ext_gnt,
    output logic [NUM_EXT-1:0]        ext_done,
    output logic [NUM_EXT-1:0]        ext_fault,
    output word_t                     ext_rdata,
    output logic                      req_mem,
    output word_t                     mem_addr,
    output word_t                     mem_store,
    output logic                      mem_ren,
    output logic                      mem_wen,
    input  word_t                     mem_load,
    input  logic                      mem_busy,
    input  logic                      flush,
    output logic                      memory_stall
);

    localparam int IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_EXT-1:0] pick_gnt;
    logic               pick_any;
    logic [NUM_EXT-1:0] valid_req;
    logic [NUM_EXT-1:0] illegal_req;
    logic [CNT_W-1:0]   busy_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               timeout_hit;

    // A requester keeps its request up during its done/fault pulse; mask it there.
    assign valid_req   = ext_req & (ext_ren ^ ext_wen) & ~ext_done & ~ext_fault;
    assign illegal_req = ext_req & ~(ext_ren ^ ext_wen) & ~ext_fault;

    assign cnt_nxt     = (busy_cnt == CNT_W'(TIMEOUT)) ? busy_cnt : busy_cnt + CNT_W'(1);
    assign timeout_hit = mem_busy && (cnt_nxt == CNT_W'(TIMEOUT));

    assign req_mem      = (state != IDLE);
    assign memory_stall = ~RST & (req_mem | (|valid_req));

    rr_picker #(
        .NUM_EXT (NUM_EXT),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid (valid_req),
        .last  (last),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_EXT - 1);
            owner     <= '0;
            ext_gnt   <= '0;
            ext_done  <= '0;
            ext_fault <= '0;
            ext_rdata <= '0;
            mem_addr  <= '0;
            mem_store <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            ext_done  <= '0;
            ext_fault <= '0;
            case (state)
                IDLE: begin
                    ext_fault <= illegal_req;
                    if (!flush && pick_any) begin
                        state     <= ACCESS;
                        owner     <= pick_idx;
                        ext_gnt   <= pick_gnt;
                        mem_addr  <= ext_addr[pick_idx*WORD_W +: WORD_W];
                        mem_store <= ext_wdata[pick_idx*WORD_W +: WORD_W];
                        mem_ren   <= ext_ren[pick_idx];
                        mem_wen   <= ext_wen[pick_idx];
                        busy_cnt  <= '0;
                    end
                end
                ACCESS: begin
                    if (!mem_busy) begin
                        // A flush racing completion lets the access finish but hides the result.
                        if (!flush) begin
                            ext_rdata <= mem_load;
                            ext_done  <= ext_gnt;
                            last      <= owner;
                        end
                        state   <= IDLE;
                        ext_gnt <= '0;
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                    end else if (timeout_hit) begin
                        ext_fault <= ext_gnt;
                        last      <= owner;
                        state     <= IDLE;
                        ext_gnt   <= '0;
                        mem_ren   <= 1'b0;
                        mem_wen   <= 1'b0;
                    end else begin
                        busy_cnt <= cnt_nxt;
                        if (flush) begin
                            state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    if (!mem_busy || timeout_hit) begin
                        state   <= IDLE;
                        ext_gnt <= '0;
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                    end else begin
                        busy_cnt <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
